// File: rtl/elevador_pkg.sv
// Shared types and defaults for the elevator scheduler.
//   estado_t  : scheduler FSM states (PARADO, MOVENDO, PORTA_ABERTA)
//   direcao_t : travel direction / SCAN preference (SOBE, DESCE)
//   NUM_ANDARES_PADRAO : default floor count
//   larg_andar(n)      : width of a floor index for n floors
package elevador_pkg;

  typedef enum logic [1:0] {
    PARADO       = 2'd0,
    MOVENDO      = 2'd1,
    PORTA_ABERTA = 2'd2
  } estado_t;

  typedef enum logic {
    SOBE  = 1'b0,
    DESCE = 1'b1
  } direcao_t;

  localparam int NUM_ANDARES_PADRAO = 4;

  // A single-floor building still needs a 1-bit floor index.
  function automatic int larg_andar(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/contador_ticks.sv
// Loadable down-counter shared by travel and door timing.
// Ports:
//   clock_in, reset : system clock, synchronous active-high reset
//   carga, valor    : load request and load value (load beats decrement)
//   tick            : decrement enable
//   fim             : high when the count is 1 and a tick arrives, i.e. the
//                     interval expires on this edge
module contador_ticks #(
  parameter int LARGURA = 2
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               carga,
  input  logic [LARGURA-1:0] valor,
  input  logic               tick,
  output logic               fim
);

  logic [LARGURA-1:0] contagem;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      contagem <= '0;
    end else if (carga) begin
      // A tick on the loading edge is deliberately not counted.
      contagem <= valor;
    end else if (tick && (contagem != '0)) begin
      contagem <= contagem - LARGURA'(1);
    end
  end

  assign fim = tick && (contagem == LARGURA'(1));

endmodule

// File: rtl/escalonador_chamadas.sv
// Elevator call scheduler and motion sequencer (SCAN policy).
// Latches floor calls, keeps moving in the preferred direction while calls
// remain ahead, times floor-to-floor travel and door-open intervals from the
// divided-clock tick.
// Ports:
//   clock_in, reset : system clock, synchronous active-high reset
//   emergencia      : only with PARADA_EMERGENCIA_EN defined; freezes timers
//                     and the FSM while high (calls keep latching)
//   tick            : one-cycle enable from the frequency divider
//   botoes          : call buttons, bit i = floor i
//   andar_atual     : current floor
//   subindo/descendo: cabin moving up / down
//   porta_aberta    : door open
//   pendentes       : latched, unserved calls
// Optional feature macro: PARADA_EMERGENCIA_EN
module escalonador_chamadas
  import elevador_pkg::*;
#(
  parameter int NUM_ANDARES = NUM_ANDARES_PADRAO,
  parameter int TICKS_ANDAR = 2,
  parameter int TICKS_PORTA = 3,
  localparam int LARG_ANDAR = larg_andar(NUM_ANDARES)
) (
  input  logic                   clock_in,
  input  logic                   reset,
`ifdef PARADA_EMERGENCIA_EN
  input  logic                   emergencia,
`endif
  input  logic                   tick,
  input  logic [NUM_ANDARES-1:0] botoes,
  output logic [LARG_ANDAR-1:0]  andar_atual,
  output logic                   subindo,
  output logic                   descendo,
  output logic                   porta_aberta,
  output logic [NUM_ANDARES-1:0] pendentes
);

  localparam int TICKS_MAX = (TICKS_ANDAR > TICKS_PORTA) ? TICKS_ANDAR : TICKS_PORTA;
  localparam int LARG_CONT = $clog2(TICKS_MAX + 1);

  estado_t                estado, estado_n;
  direcao_t               dir, dir_n;
  logic [LARG_ANDAR-1:0]  andar_n, vizinho;
  logic [NUM_ANDARES-1:0] efetivas, servidos;
  logic                   acima, abaixo;
  logic                   carga, fim, tick_ef, congelado;
  logic [LARG_CONT-1:0]   valor_carga;

`ifdef PARADA_EMERGENCIA_EN
  assign congelado = emergencia;
`else
  assign congelado = 1'b0;
`endif

  assign tick_ef = tick && !congelado;

  // A press on the deciding edge already counts.
  assign efetivas = pendentes | botoes;

  // Floor the cabin reaches when the current travel interval expires.
  assign vizinho = (dir == SOBE) ? andar_atual + LARG_ANDAR'(1)
                                 : andar_atual - LARG_ANDAR'(1);

  always_comb begin
    acima  = 1'b0;
    abaixo = 1'b0;
    for (int i = 0; i < NUM_ANDARES; i++) begin
      if (efetivas[i]) begin
        if (LARG_ANDAR'(i) > andar_atual) acima  = 1'b1;
        if (LARG_ANDAR'(i) < andar_atual) abaixo = 1'b1;
      end
    end
  end

  always_comb begin
    estado_n    = estado;
    dir_n       = dir;
    andar_n     = andar_atual;
    carga       = 1'b0;
    valor_carga = LARG_CONT'(TICKS_ANDAR);
    servidos    = '0;
    // While frozen the FSM holds; only call latching continues.
    if (!congelado) begin
      unique case (estado)
        PARADO: begin
          if (efetivas[andar_atual]) begin
            estado_n              = PORTA_ABERTA;
            carga                 = 1'b1;
            valor_carga           = LARG_CONT'(TICKS_PORTA);
            servidos[andar_atual] = 1'b1;
          end else if ((dir == SOBE) ? acima : abaixo) begin
            estado_n = MOVENDO;
            carga    = 1'b1;
          end else if ((dir == SOBE) ? abaixo : acima) begin
            dir_n    = (dir == SOBE) ? DESCE : SOBE;
            estado_n = MOVENDO;
            carga    = 1'b1;
          end
        end
        MOVENDO: begin
          if (fim) begin
            andar_n = vizinho;
            carga   = 1'b1;
            if (efetivas[vizinho]) begin
              estado_n          = PORTA_ABERTA;
              valor_carga       = LARG_CONT'(TICKS_PORTA);
              servidos[vizinho] = 1'b1;
            end
          end
        end
        PORTA_ABERTA: begin
          // A new call here keeps the door open; it beats expiry.
          if (efetivas[andar_atual]) begin
            carga                 = 1'b1;
            valor_carga           = LARG_CONT'(TICKS_PORTA);
            servidos[andar_atual] = 1'b1;
          end else if (fim) begin
            estado_n = PARADO;
          end
        end
        default: estado_n = PARADO;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      estado      <= PARADO;
      dir         <= SOBE;
      andar_atual <= '0;
      pendentes   <= '0;
    end else begin
      estado      <= estado_n;
      dir         <= dir_n;
      andar_atual <= andar_n;
      pendentes   <= efetivas & ~servidos;
    end
  end

  contador_ticks #(
    .LARGURA(LARG_CONT)
  ) u_contador (
    .clock_in(clock_in),
    .reset   (reset),
    .carga   (carga),
    .valor   (valor_carga),
    .tick    (tick_ef),
    .fim     (fim)
  );

  // Pure decodes of registered state: no input reaches these combinationally.
  assign subindo      = (estado == MOVENDO) && (dir == SOBE);
  assign descendo     = (estado == MOVENDO) && (dir == DESCE);
  assign porta_aberta = (estado == PORTA_ABERTA);

endmodule
